// File: rtl/mem_lsu_if.sv
// mem_lsu_if: bundles the pipeline request/response handshake and the RAM
// data-port signals of the MEM-stage load/store unit.
//   slave  modport: the LSU side (drives ready, response and RAM address/data/we)
//   master modport: the pipeline + RAM side (drives requests and the RAM read word)
`ifndef XLEN
`define XLEN 32
`endif

interface mem_lsu_if #(
    parameter int XLEN = `XLEN
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_store_i;
    logic [2:0]      req_funct3_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic [XLEN-1:0] ram_addr_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic            mem_we_o;
    logic [XLEN-1:0] ram_rdata_i;

    modport slave (
        input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ram_addr_o, ram_wdata_o, mem_we_o
    );

    modport master (
        output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ram_addr_o, ram_wdata_o, mem_we_o
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit in front of the shared RAM data port.
// Converts between RAM word packing (byte offset 0 in bits 31:24) and
// little-endian architectural values. Sub-word stores are done as
// read-modify-write because the RAM only writes whole words.
// Ports:
//   clk_i  - clock, all state on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - mem_lsu_if.slave: request/response handshake and RAM port
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word accesses respond with rsp_err_o
//   undefined - misaligned addresses are truncated to natural alignment
// Lane logic assumes XLEN = 32.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | ready for a request
// S_LOAD  | RAM addressed, extract/extend the load result
// S_READ  | RAM addressed, merge store bytes into old word
// S_WRITE | write enable asserted for one cycle
// S_RESP  | rsp_valid_o pulse
`ifndef XLEN
`define XLEN 32
`endif

module mem_lsu #(
    parameter int XLEN        = `XLEN,
    parameter int ADDR_MASK_W = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mem_lsu_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WRITE, S_RESP} state_t;

    // Keeps address bits [ADDR_MASK_W-1:2]; everything else forced to zero.
    function automatic logic [XLEN-1:0] word_mask();
        logic [XLEN-1:0] m;
        m = '0;
        for (int i = 2; i < XLEN; i++) m[i] = (i < ADDR_MASK_W);
        return m;
    endfunction

    localparam logic [XLEN-1:0] WORD_MASK = word_mask();

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [15:0]     r_wdata;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [XLEN-1:0] r_rsp_rdata;
    logic [XLEN-1:0] r_ram_addr;
    logic [XLEN-1:0] r_ram_wdata;   // doubles as the RMW merge register
    logic            r_we;

    logic            w_illegal;
    logic            w_err;
    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merge;
    logic [XLEN-1:0] w_rd;
    logic [XLEN-1:0] w_wd;

    assign w_rd = bus.ram_rdata_i;
    assign w_wd = bus.req_wdata_i;

    always_comb begin
        if (bus.req_store_i) w_illegal = (bus.req_funct3_i > 3'b010);
        else                 w_illegal = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i[2:1] == 2'b11);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                        ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
    assign w_err = w_illegal || w_misalign;
    assign w_off = bus.req_addr_i[1:0];
`else
    assign w_err = w_illegal;
    // Misaligned accesses are silently rounded down to natural alignment.
    always_comb begin
        case (bus.req_funct3_i[1:0])
            2'b01:   w_off = {bus.req_addr_i[1], 1'b0};
            2'b10:   w_off = 2'b00;
            default: w_off = bus.req_addr_i[1:0];
        endcase
    end
`endif

    always_comb begin
        case (r_off)
            2'd0:    w_byte = w_rd[31:24];
            2'd1:    w_byte = w_rd[23:16];
            2'd2:    w_byte = w_rd[15:8];
            default: w_byte = w_rd[7:0];
        endcase
        w_half = r_off[1] ? {w_rd[7:0], w_rd[15:8]} : {w_rd[23:16], w_rd[31:24]};
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b010:  w_load = {w_rd[7:0], w_rd[15:8], w_rd[23:16], w_rd[31:24]};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_merge = w_rd;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_off)
                2'd0:    w_merge[31:24] = r_wdata[7:0];
                2'd1:    w_merge[23:16] = r_wdata[7:0];
                2'd2:    w_merge[15:8]  = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_off[1]) begin
            w_merge[15:0]  = {r_wdata[7:0], r_wdata[15:8]};
        end else begin
            w_merge[31:16] = {r_wdata[7:0], r_wdata[15:8]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_funct3    <= '0;
            r_off       <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_we        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_funct3    <= bus.req_funct3_i;
                        r_off       <= w_off;
                        r_wdata     <= w_wd[15:0];
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= '0;
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_ram_addr <= bus.req_addr_i & WORD_MASK;
                            if (!bus.req_store_i) begin
                                r_state <= S_LOAD;
                            end else if (bus.req_funct3_i[1:0] == 2'b10) begin
                                r_ram_wdata <= {w_wd[7:0], w_wd[15:8], w_wd[23:16], w_wd[31:24]};
                                r_we        <= 1'b1;
                                r_state     <= S_WRITE;
                            end else begin
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rsp_rdata <= w_load;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_READ: begin
                    r_ram_wdata <= w_merge;
                    r_we        <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (r_state == S_IDLE);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.ram_addr_o  = r_ram_addr;
    assign bus.ram_wdata_o = r_ram_wdata;
    // Combinational gate so a reset cycle can never write the RAM.
    assign bus.mem_we_o    = r_we && !rst_i;
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the MEM stage of the five-stage RISB core; sits directly upstream of the data port of the shared dual-port RAM.
- Drives the RAM address, write data and write enable; consumes the RAM's combinational read word.
- Converts between the RAM's word packing (byte offset 0 in bits 31:24) and little-endian architectural values.
- Implements LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores use a read-modify-write sequence because the RAM only writes whole words.

Parameters:
- XLEN, 32 (`XLEN), data and address width.
- ADDR_MASK_W, 32, number of low address bits passed to the RAM; upper bits are driven 0.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  pipeline presents a memory op.
- req_ready_o  out  1  LSU accepts the op this cycle; the pipeline stalls while this is low.
- req_store_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RISC-V funct3 of the op.
- req_addr_i  in  XLEN  byte address.
- req_wdata_i  in  XLEN  store data, little-endian, low bytes used for SB/SH.
- rsp_valid_o  out  1  one-cycle pulse; op complete.
- rsp_rdata_o  out  XLEN  load result, extended; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal op; qualified by rsp_valid_o.
- ram_addr_o  out  XLEN  word address to RAM; low 2 bits always 0.
- ram_wdata_o  out  XLEN  word to RAM in RAM packing.
- mem_we_o  out  1  RAM write enable.
- ram_rdata_i  in  XLEN  combinational RAM read word.

Behaviour:
- Reset values: state IDLE; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, ram_addr_o=0, ram_wdata_o=0, mem_we_o=0, all latches 0.
- mem_we_o is gated by !rst_i, so no RAM write occurs in a cycle where rst_i=1, whatever the state.
- Lane map: byte offset k of a word is ram bits [31-8k -: 8]. Architectural byte k is bits [8k+7:8k].
- FSM states: IDLE, LOAD, READ, WRITE, RESP. req_ready_o=1 only in IDLE.
- IDLE, on accept (req_valid_i=1):
  - Latch addr, funct3, store flag and wdata.
  - Compute the error flag: illegal funct3 (load 011/110/111; store other than 000/001/010), halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Next state: error -> RESP; load -> LOAD; SW -> WRITE; SB/SH -> READ.
- LOAD:
  - ram_addr_o = latched word address.
  - Extract the byte or halfword from ram_rdata_i using the lane map.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW returns the lane-swapped word.
  - Register the result into rsp_rdata_o; go to RESP.
- READ: ram_addr_o = word address; capture ram_rdata_i merged with the new store bytes into the merge register; go to WRITE.
- WRITE:
  - ram_addr_o = word address; ram_wdata_o = merge register (SW: lane-swapped req data).
  - mem_we_o=1 for exactly this cycle; go to RESP.
- RESP: rsp_valid_o=1 for one cycle with rsp_err_o/rsp_rdata_o valid; return to IDLE. The next request can be accepted the cycle after RESP.
- Latency from the accept edge to rsp_valid_o:
  - Load: 2 cycles.
  - SW: 2 cycles; write issued in cycle 1.
  - SB/SH: 3 cycles; write issued in cycle 2.
  - Error: 1 cycle.
- Erroring ops never assert mem_we_o.
- Reset in any state aborts the op: no response and no write; back to IDLE on the reset edge.
- Outside LOAD/READ/WRITE, ram_addr_o holds its last value and mem_we_o=0.
- Address width: the word address is req_addr_i[ADDR_MASK_W-1:2]; higher bits are zero-filled. The RAM wraps internally, and the LSU performs no range check.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: misaligned H/W accesses take the error path described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misalignment is not an error. The address is truncated to natural alignment (H: addr[0] cleared; W: addr[1:0] cleared) and the op proceeds normally.
  - rsp_err_o is asserted only for illegal funct3.

Test Plan:
- RAM word at 0x100 = 0x11228344; LW 0x100 -> rsp at accept+2, rdata=0x44832211, err=0, mem_we_o never 1.
- Same word; LB 0x102 -> 0xFFFFFF83; LBU 0x102 -> 0x00000083; LH 0x102 -> 0x00004483; LHU 0x100 -> 0x00002211.
- SB addr 0x101 wdata 0x000000AB on word 0x11228344 -> mem_we_o=1 only at accept+2, ram_addr_o=0x100, ram_wdata_o=0x11AB8344; rsp at accept+3.
- SW 0x104 wdata 0xDEADBEEF -> write at accept+1 with ram_wdata_o=0xEFBEADDE; req_ready_o low until the cycle after RESP.
- With the macro defined: SH 0x101 -> rsp at accept+1, err=1, rdata=0, no write. Without it: writes the halfword at offsets 0-1 of 0x100.
- SB accepted, rst_i=1 during READ -> mem_we_o=0 throughout, no rsp_valid_o, FSM IDLE and req_ready_o=1 after the reset edge.
